sumador_etapa_captura: RTL and testbench
========================================

Name: sumador_etapa_captura

Overview:
- Operand-issue and result-capture stage wrapped around the gate-level 8-bit ripple adder.
- Accepts an operand pair through a valid/ready handshake and drives the adder inputs from registers.
- Waits a fixed ripple-settle interval, then registers sum and carry-out and presents them downstream through a second valid/ready handshake.
- Gives the power-analysis flow a clean, clocked boundary so adder switching activity is confined to known cycles.

Parameters:
- WIDTH, 8, operand/sum width; must match the attached adder.
- SETTLE, 2, clock cycles the adder outputs are allowed to settle before capture; legal range 1..15.
- PwrC, 0, power-characterisation tag carried for the flow; no functional effect.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  stage can accept an operand pair
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_ci  input  1  carry-in
- add_a  output  WIDTH  registered operand A to adder
- add_b  output  WIDTH  registered operand B to adder
- add_ci  output  1  registered carry-in to adder
- add_s  input  WIDTH  adder sum
- add_co  input  1  adder carry-out
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_s  output  WIDTH  captured sum
- out_co  output  1  captured carry-out
- busy  output  1  high in WAIT or OUT

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset is sampled on the clk rising edge. It forces state IDLE, settle counter 0, and add_a/add_b/add_ci/out_s/out_co/out_valid all 0.
- Derived outputs:
  - in_ready = (state==IDLE) && !reset.
  - busy = (state!=IDLE).
- IDLE:
  - On in_valid && in_ready: latch in_a/in_b/in_ci into add_a/add_b/add_ci, load counter with SETTLE, go to WAIT.
  - If in_valid is low, add_* keep their last values; the adder inputs must not toggle.
- WAIT:
  - Counter decrements every cycle.
  - On the edge where counter==1: capture add_s into out_s and add_co into out_co, set out_valid=1, go to OUT.
  - out_valid therefore rises exactly SETTLE edges after the accept edge.
- OUT:
  - out_valid, out_s and out_co hold stable while out_ready=0.
  - On out_valid && out_ready: clear out_valid and go to IDLE. in_ready rises the following cycle.
  - out_s/out_co keep their last values after the handshake.
- in_valid is ignored outside IDLE; there is no overlap or pipelining. Throughput is one operation per SETTLE+2 cycles minimum.
- Reset in WAIT or OUT aborts the operation. No out_valid pulse is produced, and all registered outputs clear on that edge.
- Arithmetic is performed entirely by the external adder. The stage does not check or modify add_s/add_co; width truncation is the adder's concern.
- in_* may change freely when not being accepted; only the accept edge is sampled.

Optional Feature:
- Macro PWR_TOGGLE_CNT_EN.
- When defined:
  - Adds output tog_cnt [15:0].
  - At every capture edge, tog_cnt += popcount({out_s,out_co} XOR {add_s,add_co}), i.e. the number of result bits that change.
  - tog_cnt saturates at 16'hFFFF and clears on reset.
  - tog_cnt is readable at any time and gives switching-activity data for power estimation.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset held 3 cycles then released:
  - During reset: all outputs 0 and in_ready=0.
  - First cycle after release: in_ready=1, busy=0.
- Ideal adder model, SETTLE=2, accept in_a=8'h3C, in_b=8'h0F, in_ci=0:
  - add_a=8'h3C on the next cycle.
  - out_valid rises 2 edges after the accept edge with out_s=8'h4B, out_co=0.
- Overflow cases:
  - in_a=8'hFF, in_b=8'h01, in_ci=0 -> out_s=8'h00, out_co=1.
  - in_a=8'hFF, in_b=8'hFF, in_ci=1 -> out_s=8'hFF, out_co=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid while in_valid=1 with new operands:
  - out_s/out_co stay stable, in_ready=0, and add_a is unchanged.
  - Raising out_ready completes the handshake, and in_ready=1 the next cycle.
- Reset asserted one cycle into WAIT: out_valid never asserts, out_s=0 and add_a=0 after the edge, and state returns to IDLE.
- PWR_TOGGLE_CNT_EN defined:
  - 8'h00+8'h00 (ci=0) -> result 0x000, tog_cnt=0.
  - Then 8'hFF+8'h01 -> result {8'h00,1}, tog_cnt=1.
  - Then 8'h7F+8'h00 -> result {8'h7F,0}, tog_cnt=9.

Source files
------------

// File: rtl/sumador_etapa_captura.sv
// sumador_etapa_captura
// Operand-issue / result-capture stage wrapped around an external ripple adder.
// An operand pair is accepted through a valid/ready handshake and held in
// registers that drive the adder. After SETTLE clock edges the adder's sum and
// carry-out are registered and offered downstream through a second handshake.
// Adder inputs only change on an accept edge, so adder switching activity is
// confined to known cycles.
//
// Optional feature, selected by the macro PWR_TOGGLE_CNT_EN:
//   adds output tog_cnt[15:0], a saturating count of result bits that change
//   at each capture edge.
//
// Parameters:
//   WIDTH  - operand/sum width, must match the attached adder
//   SETTLE - adder settle interval in clock edges, legal range 1..15
//   PwrC   - power-characterisation tag for the flow, no functional effect
module sumador_etapa_captura #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 2,
  parameter int PwrC   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_ci,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_ci,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_co,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_co,
  output logic             busy
`ifdef PWR_TOGGLE_CNT_EN
  ,
  output logic [15:0]      tog_cnt
`endif
);

  // The tag is carried for the power flow only; it never alters the counter
  // width, it is merely referenced so it stays attached to the netlist.
  localparam int CNT_W = 4 + ((PwrC != 0) ? 0 : 0);

  // Settle interval as a counter-width constant; SETTLE is limited to 1..15.
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);

  // Stage states.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  // Registered state.
  logic [1:0]       state_r;
  logic [CNT_W-1:0] cnt_r;

  // Next-state values.
  logic [1:0]       state_s;
  logic [CNT_W-1:0] cnt_s;
  logic [WIDTH-1:0] add_a_s;
  logic [WIDTH-1:0] add_b_s;
  logic             add_ci_s;
  logic [WIDTH-1:0] out_s_s;
  logic             out_co_s;
  logic             out_valid_s;
  logic             capture_s;

  // Handshake status is derived directly from the state; in_ready is also
  // masked by reset so nothing is offered on a reset edge.
  assign in_ready = (state_r == ST_IDLE) && !reset;
  assign busy     = (state_r != ST_IDLE);

  // Next-state and datapath-load decisions for the issue/capture sequence.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    add_a_s     = add_a;
    add_b_s     = add_b;
    add_ci_s    = add_ci;
    out_s_s     = out_s;
    out_co_s    = out_co;
    out_valid_s = out_valid;
    capture_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Operands are sampled only on the accept edge; otherwise the adder
        // inputs hold so the adder does not toggle.
        if (in_valid) begin
          add_a_s  = in_a;
          add_b_s  = in_b;
          add_ci_s = in_ci;
          cnt_s    = SETTLE_LOAD;
          state_s  = ST_WAIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // The last settle edge captures the adder result.
        if (cnt_r == CNT_ONE) begin
          out_s_s     = add_s;
          out_co_s    = add_co;
          out_valid_s = 1'b1;
          capture_s   = 1'b1;
          cnt_s       = CNT_ZERO;
          state_s     = ST_OUT;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      ST_OUT: begin
        // Result holds until downstream takes it; captured data stays
        // visible afterwards.
        if (out_ready) begin
          out_valid_s = 1'b0;
          state_s     = ST_IDLE;
        end else begin
          out_valid_s = 1'b1;
        end
      end
      default: begin
        // Unreachable encoding: fall back to a quiet idle stage.
        out_valid_s = 1'b0;
        cnt_s       = CNT_ZERO;
        state_s     = ST_IDLE;
      end
    endcase
  end

  // State, adder-operand and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      add_a     <= {WIDTH{1'b0}};
      add_b     <= {WIDTH{1'b0}};
      add_ci    <= 1'b0;
      out_s     <= {WIDTH{1'b0}};
      out_co    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      add_a     <= add_a_s;
      add_b     <= add_b_s;
      add_ci    <= add_ci_s;
      out_s     <= out_s_s;
      out_co    <= out_co_s;
      out_valid <= out_valid_s;
    end
  end

`ifdef PWR_TOGGLE_CNT_EN
  // Number of set bits in a result-wide vector.
  function automatic logic [15:0] popcount(input logic [WIDTH:0] v);
    logic [15:0] n;
    n = 16'd0;
    for (int i = 0; i <= WIDTH; i++) begin
      n = n + {15'd0, v[i]};
    end
    return n;
  endfunction

  logic [15:0] toggles_s;
  logic [16:0] tog_sum_s;
  logic [15:0] tog_next_s;

  // Bits of the captured result that flip on a capture edge, added with
  // saturation at all-ones.
  always_comb begin
    toggles_s  = popcount({out_s, out_co} ^ {add_s, add_co});
    tog_sum_s  = {1'b0, tog_cnt} + {1'b0, toggles_s};
    tog_next_s = tog_cnt;
    if (capture_s) begin
      if (tog_sum_s[16]) begin
        tog_next_s = 16'hFFFF;
      end else begin
        tog_next_s = tog_sum_s[15:0];
      end
    end else begin
      tog_next_s = tog_cnt;
    end
  end

  // Switching-activity accumulator, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      tog_cnt <= 16'd0;
    end else begin
      tog_cnt <= tog_next_s;
    end
  end
`else
  logic unused_capture_s;

  // The capture strobe only feeds the optional activity counter.
  always_comb begin
    unused_capture_s = capture_s;
  end
`endif

endmodule

// File: tb/tb_sumador_etapa_captura.sv
// Self-checking bench for sumador_etapa_captura with an ideal adder attached.
// Expected results are pushed to a scoreboard queue at operand issue and
// popped when the stage presents its result.
module tb_sumador_etapa_captura;

  localparam int WIDTH  = 8;
  localparam int SETTLE = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_ci;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_ci;
  logic [WIDTH-1:0] add_s;
  logic             add_co;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_s;
  logic             out_co;
  logic             busy;
`ifdef PWR_TOGGLE_CNT_EN
  logic [15:0]      tog_cnt;
  logic [15:0]      tog_model;
  logic [8:0]       prev_res;
`endif

  int checks   = 0;
  int failures = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  // Ideal adder driven by the stage's registered operands.
  assign {add_co, add_s} = 9'(add_a) + 9'(add_b) + 9'(add_ci);

  sumador_etapa_captura #(.WIDTH(WIDTH), .SETTLE(SETTLE), .PwrC(0)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_ci     (in_ci),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_ci    (add_ci),
    .add_s     (add_s),
    .add_co    (add_co),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_co    (out_co),
    .busy      (busy)
`ifdef PWR_TOGGLE_CNT_EN
    ,
    .tog_cnt   (tog_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one operand pair from a negedge in IDLE, optionally stall the
  // result for 'stall' cycles with new operands offered, then complete.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic [8:0] exp_res, input int stall);
    logic [8:0] got;
    logic [7:0] held_s;
    logic       held_co;
    int edges;
    in_a = a; in_b = b; in_ci = ci; in_valid = 1'b1;
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    exp_q.push_back(exp_res);
    @(negedge clk);
    in_valid = 1'b0; in_a = ~a; in_b = ~b; in_ci = ~ci;
    chk("add_a_issued", 32'(add_a), 32'(a));
    chk("add_b_issued", 32'(add_b), 32'(b));
    chk("add_ci_issued", 32'(add_ci), 32'(ci));
    chk("busy_wait", 32'(busy), 32'd1);
    edges = 0;
    while (!out_valid && edges < 32) begin
      @(negedge clk);
      edges++;
    end
    chk("latency", 32'(edges), 32'(SETTLE));
    if (stall > 0) begin
      out_ready = 1'b0;
      in_valid = 1'b1; in_a = 8'hA5; in_b = 8'h5A; in_ci = 1'b1;
      held_s = out_s; held_co = out_co;
      repeat (stall) begin
        @(negedge clk);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_out_s", 32'(out_s), 32'(held_s));
        chk("bp_out_co", 32'(out_co), 32'(held_co));
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_add_a", 32'(add_a), 32'(a));
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd1);
      got = 9'h000;
    end else begin
      got = exp_q.pop_front();
    end
    chk("result", 32'({out_co, out_s}), 32'(got));
`ifdef PWR_TOGGLE_CNT_EN
    if (17'(tog_model) + 17'($countones(prev_res ^ got)) > 17'h0FFFF) tog_model = 16'hFFFF;
    else tog_model = tog_model + 16'($countones(prev_res ^ got));
    prev_res = got;
    chk("tog_cnt_model", 32'(tog_cnt), 32'(tog_model));
`endif
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_cleared", 32'(out_valid), 32'd0);
    chk("in_ready_after_hs", 32'(in_ready), 32'd1);
    chk("busy_after_hs", 32'(busy), 32'd0);
    chk("result_kept", 32'({out_co, out_s}), 32'(got));
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    reset = 1'b1; in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00; in_ci = 1'b0;
    out_ready = 1'b0;
`ifdef PWR_TOGGLE_CNT_EN
    tog_model = 16'd0; prev_res = 9'd0;
`endif
    // Reset held for three cycles.
    repeat (3) begin
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out", 32'({out_co, out_s}), 32'd0);
      chk("rst_add", 32'({add_ci, add_a, add_b}), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);

`ifdef PWR_TOGGLE_CNT_EN
    chk("tog_after_reset", 32'(tog_cnt), 32'd0);
    run_op(8'h00, 8'h00, 1'b0, 9'h000, 0);
    chk("tog_zero_op", 32'(tog_cnt), 32'd0);
    run_op(8'hFF, 8'h01, 1'b0, 9'h100, 0);
    chk("tog_one", 32'(tog_cnt), 32'd1);
    run_op(8'h7F, 8'h00, 1'b0, 9'h07F, 0);
    chk("tog_nine", 32'(tog_cnt), 32'd9);
`endif

    // Directed arithmetic cases, including carry-out boundaries.
    run_op(8'h3C, 8'h0F, 1'b0, 9'h04B, 0);
    run_op(8'hFF, 8'h01, 1'b0, 9'h100, 0);
    run_op(8'hFF, 8'hFF, 1'b1, 9'h1FF, 0);
    // Backpressure with fresh operands offered meanwhile.
    run_op(8'h12, 8'h34, 1'b1, 9'h047, 5);
    // A few random operand pairs.
    repeat (4) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      run_op(ra, rb, rc, 9'(ra) + 9'(rb) + 9'(rc), 0);
    end
    run_op(8'h80, 8'h01, 1'b0, 9'h081, 0);

    // Reset one cycle into WAIT aborts the operation.
    in_a = 8'h55; in_b = 8'h22; in_ci = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("abort_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_out_s", 32'(out_s), 32'd0);
    chk("abort_out_co", 32'(out_co), 32'd0);
    chk("abort_add_a", 32'(add_a), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_in_ready_rst", 32'(in_ready), 32'd0);
`ifdef PWR_TOGGLE_CNT_EN
    chk("abort_tog", 32'(tog_cnt), 32'd0);
    tog_model = 16'd0; prev_res = 9'd0;
`endif
    reset = 1'b0;
    repeat (SETTLE + 3) begin
      @(negedge clk);
      chk("abort_no_valid", 32'(out_valid), 32'd0);
    end
    chk("abort_idle_ready", 32'(in_ready), 32'd1);
    chk("abort_idle_busy", 32'(busy), 32'd0);

    // Normal operation resumes after the abort.
    run_op(8'h01, 8'h02, 1'b0, 9'h003, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
